// File: rtl/simmem_mem_responder.sv
// -----------------------------------------------------------------------------
// simmem_mem_responder
//
// Memory endpoint for the far side of the simulated memory controller. It
// accepts read-address, write-address and write-data requests and answers them
// with read-data bursts and write responses from an internal word-addressed
// store. Reads and writes run on two independent FSMs, each with at most one
// outstanding transaction.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   raddr_valid_i/ready_o        read request handshake
//   raddr_id_i/addr_i/len_i      read id, first word address, beats-1
//   waddr_valid_i/ready_o        write request handshake
//   waddr_id_i/addr_i/len_i      write id, first word address, beats-1
//   wdata_valid_i/ready_o        write beat handshake
//   wdata_data_i/last_i          write beat payload and final-beat marker
//   rdata_valid_o/ready_i        read beat handshake
//   rdata_id_o/data_o/last_o     read beat id, payload and final-beat marker
//   wresp_valid_o/ready_i        write response handshake
//   wresp_id_o/resp_o            write id and status (00 OKAY, 10 SLVERR)
// -----------------------------------------------------------------------------
module simmem_mem_responder #(
  parameter int IDWidth       = 4,
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 32,
  parameter int BurstLenWidth = 4,
  parameter int MemWordsLog   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     raddr_valid_i,
  output logic                     raddr_ready_o,
  input  logic [IDWidth-1:0]       raddr_id_i,
  input  logic [AddrWidth-1:0]     raddr_addr_i,
  input  logic [BurstLenWidth-1:0] raddr_len_i,

  input  logic                     waddr_valid_i,
  output logic                     waddr_ready_o,
  input  logic [IDWidth-1:0]       waddr_id_i,
  input  logic [AddrWidth-1:0]     waddr_addr_i,
  input  logic [BurstLenWidth-1:0] waddr_len_i,

  input  logic                     wdata_valid_i,
  output logic                     wdata_ready_o,
  input  logic [DataWidth-1:0]     wdata_data_i,
  input  logic                     wdata_last_i,

  output logic                     rdata_valid_o,
  input  logic                     rdata_ready_i,
  output logic [IDWidth-1:0]       rdata_id_o,
  output logic [DataWidth-1:0]     rdata_data_o,
  output logic                     rdata_last_o,

  output logic                     wresp_valid_o,
  input  logic                     wresp_ready_i,
  output logic [IDWidth-1:0]       wresp_id_o,
  output logic [1:0]               wresp_resp_o
);

  localparam int                     MemWords = 1 << MemWordsLog;
  localparam logic [MemWordsLog-1:0] IdxOne   = MemWordsLog'(1);
  localparam logic [BurstLenWidth-1:0] CntOne = BurstLenWidth'(1);

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Read-side state
  r_state_e                 r_rstate;
  logic [IDWidth-1:0]       r_rid;
  logic [MemWordsLog-1:0]   r_ridx;
  logic [BurstLenWidth-1:0] r_rlen;
  logic [BurstLenWidth-1:0] r_rcnt;

  // Write-side state
  w_state_e                 r_wstate;
  logic [IDWidth-1:0]       r_wid;
  logic [MemWordsLog-1:0]   r_widx;
  logic [BurstLenWidth-1:0] r_wlen;
  logic [BurstLenWidth-1:0] r_wcnt;
  logic                     r_werr;

  logic [DataWidth-1:0]     r_mem [MemWords];

  // Handshake outputs decode straight from the state registers; reset gates
  // them so nothing is offered or accepted while rst_i is high.
  logic w_raddr_ready, w_rdata_valid, w_waddr_ready, w_wdata_ready, w_wresp_valid;
  logic w_ra_fire, w_rd_fire, w_wa_fire, w_wd_fire, w_wr_fire;
  logic w_rd_last, w_wd_cnt_end, w_wd_end;

  assign w_raddr_ready = !rst_i && (r_rstate == R_IDLE);
  assign w_rdata_valid = !rst_i && (r_rstate == R_BURST);
  assign w_waddr_ready = !rst_i && (r_wstate == W_IDLE);
  assign w_wdata_ready = !rst_i && (r_wstate == W_DATA);
  assign w_wresp_valid = !rst_i && (r_wstate == W_RESP);

  assign w_ra_fire = w_raddr_ready && raddr_valid_i;
  assign w_rd_fire = w_rdata_valid && rdata_ready_i;
  assign w_wa_fire = w_waddr_ready && waddr_valid_i;
  assign w_wd_fire = w_wdata_ready && wdata_valid_i;
  assign w_wr_fire = w_wresp_valid && wresp_ready_i;

  assign w_rd_last    = (r_rcnt == r_rlen);
  assign w_wd_cnt_end = (r_wcnt == r_wlen);
  // A write burst stops at whichever comes first: the master's last marker or
  // the beat count implied by len.
  assign w_wd_end     = wdata_last_i || w_wd_cnt_end;

  // Only the low MemWordsLog address bits select a word; the rest are dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{raddr_addr_i[AddrWidth-1:MemWordsLog],
                                waddr_addr_i[AddrWidth-1:MemWordsLog]};

  assign raddr_ready_o = w_raddr_ready;
  assign waddr_ready_o = w_waddr_ready;
  assign wdata_ready_o = w_wdata_ready;
  assign rdata_valid_o = w_rdata_valid;
  assign wresp_valid_o = w_wresp_valid;

  // The store is read asynchronously; a write landing on the same word in the
  // same cycle only updates it at the clock edge, so the beat sees the old data.
  assign rdata_data_o = w_rdata_valid ? r_mem[r_ridx] : '0;
  assign rdata_last_o = w_rdata_valid && w_rd_last;
  assign rdata_id_o   = rst_i ? '0 : r_rid;
  assign wresp_id_o   = rst_i ? '0 : r_wid;
  assign wresp_resp_o = (w_wresp_valid && r_werr) ? 2'b10 : 2'b00;

  // Read FSM
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ra_fire) begin
            r_rid    <= raddr_id_i;
            r_ridx   <= raddr_addr_i[MemWordsLog-1:0];
            r_rlen   <= raddr_len_i;
            r_rcnt   <= '0;
            r_rstate <= R_BURST;
          end
        end
        R_BURST: begin
          if (w_rd_fire) begin
            r_ridx <= r_ridx + IdxOne;
            r_rcnt <= r_rcnt + CntOne;
            if (w_rd_last) r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wa_fire) begin
            r_wid    <= waddr_id_i;
            r_widx   <= waddr_addr_i[MemWordsLog-1:0];
            r_wlen   <= waddr_len_i;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wd_fire) begin
            r_widx <= r_widx + IdxOne;
            r_wcnt <= r_wcnt + CntOne;
            if (w_wd_end) begin
              // Early last, or missing last at the final counted beat.
              r_werr   <= (wdata_last_i != w_wd_cnt_end);
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_wr_fire) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // NOTE: the store has no reset; clearing every word would turn it into a
  // huge flop array and contents are defined only once written.
  always_ff @(posedge clk_i) begin
    if (w_wd_fire) r_mem[r_widx] <= wdata_data_i;
  end

endmodule

// File: tb/tb_simmem_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_simmem_mem_responder
//
// Self-checking bench for simmem_mem_responder. Inputs are driven and outputs
// sampled on the falling clock edge. A plain array mirrors the store; write
// bursts update it from the burst-termination rules and read bursts are
// compared beat by beat against it.
// -----------------------------------------------------------------------------
module tb_simmem_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        raddr_valid_i, raddr_ready_o;
  logic [3:0]  raddr_id_i;
  logic [15:0] raddr_addr_i;
  logic [3:0]  raddr_len_i;
  logic        waddr_valid_i, waddr_ready_o;
  logic [3:0]  waddr_id_i;
  logic [15:0] waddr_addr_i;
  logic [3:0]  waddr_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [31:0] wdata_data_i;
  logic        wdata_last_i;
  logic        rdata_valid_o, rdata_ready_i;
  logic [3:0]  rdata_id_o;
  logic [31:0] rdata_data_o;
  logic        rdata_last_o;
  logic        wresp_valid_o, wresp_ready_i;
  logic [3:0]  wresp_id_o;
  logic [1:0]  wresp_resp_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [256];

  simmem_mem_responder #(
    .IDWidth(4), .AddrWidth(16), .DataWidth(32), .BurstLenWidth(4), .MemWordsLog(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
    .raddr_id_i(raddr_id_i), .raddr_addr_i(raddr_addr_i), .raddr_len_i(raddr_len_i),
    .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
    .waddr_id_i(waddr_id_i), .waddr_addr_i(waddr_addr_i), .waddr_len_i(waddr_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_data_i(wdata_data_i), .wdata_last_i(wdata_last_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .rdata_id_o(rdata_id_o), .rdata_data_o(rdata_data_o), .rdata_last_o(rdata_last_o),
    .wresp_valid_o(wresp_valid_o), .wresp_ready_i(wresp_ready_i),
    .wresp_id_o(wresp_id_o), .wresp_resp_o(wresp_resp_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [3:0]  len;
    int          last_at;   // beat index carrying wdata_last_i, -1/out of range = never
    logic [31:0] base;      // beat i carries base + i
    int          exp_beats;
    logic [1:0]  exp_resp;
  } wvec_t;

  wvec_t vecs [8];

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference store update: beats are written until the first beat that either
  // carries last or reaches len; the response is OKAY only if both coincide.
  function automatic void model_write(input logic [15:0] addr, input logic [3:0] len,
                                      input int last_at, input logic [31:0] base,
                                      output int beats, output logic [1:0] resp);
    beats = 0;
    resp  = 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      ref_mem[(int'(addr) + i) % 256] = base + 32'(i);
      beats = i + 1;
      if (i == last_at || i == int'(len)) begin
        resp = (i == last_at && i == int'(len)) ? 2'b00 : 2'b10;
        break;
      end
    end
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [3:0] len,
                          input int last_at, input logic [31:0] base, input int nbeats,
                          input logic [1:0] exp_resp, input bit rand_bp, input string tag);
    int n;
    waddr_valid_i = 1'b1;
    waddr_id_i    = id;
    waddr_addr_i  = addr;
    waddr_len_i   = len;
    // First beat is offered together with the address; it must wait.
    wdata_valid_i = 1'b1;
    wdata_data_i  = base;
    wdata_last_i  = (last_at == 0);
    n = 0;
    while (!waddr_ready_o && n < 50) begin tick(); n++; end
    check({tag, "_waddr_ready"}, waddr_ready_o, 1);
    check({tag, "_wdata_held_in_idle"}, wdata_ready_o, 0);
    tick();
    waddr_valid_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (rand_bp && i > 0 && $urandom_range(0, 3) == 0) begin
        wdata_valid_i = 1'b0;
        tick();
      end
      wdata_valid_i = 1'b1;
      wdata_data_i  = base + 32'(i);
      wdata_last_i  = (i == last_at);
      n = 0;
      while (!wdata_ready_o && n < 50) begin tick(); n++; end
      check($sformatf("%s_wdata_ready_b%0d", tag, i), wdata_ready_o, 1);
      tick();
    end
    // A stray beat offered during the response phase must not be taken.
    wdata_valid_i = 1'b1;
    wdata_data_i  = 32'hDEAD_BEEF;
    wdata_last_i  = 1'b1;
    wresp_ready_i = 1'b0;
    n = 0;
    while (!wresp_valid_o && n < 50) begin tick(); n++; end
    check({tag, "_wresp_valid"}, wresp_valid_o, 1);
    check({tag, "_wdata_blocked_in_resp"}, wdata_ready_o, 0);
    check({tag, "_wresp_id"}, wresp_id_o, id);
    check({tag, "_wresp_resp"}, wresp_resp_o, exp_resp);
    if (rand_bp) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        check({tag, "_wresp_hold_valid"}, wresp_valid_o, 1);
        check({tag, "_wresp_hold_id"}, wresp_id_o, id);
        check({tag, "_wresp_hold_resp"}, wresp_resp_o, exp_resp);
      end
    end
    wresp_ready_i = 1'b1;
    tick();
    wresp_ready_i = 1'b0;
    wdata_valid_i = 1'b0;
    wdata_last_i  = 1'b0;
    check({tag, "_wresp_dropped"}, wresp_valid_o, 0);
    check({tag, "_waddr_ready_again"}, waddr_ready_o, 1);
  endtask

  // stall_at: beat index held with rdata_ready_i low for 5 cycles (-1 = none).
  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [3:0] len,
                         input int stall_at, input bit rand_bp, input string tag);
    int n;
    int stalls;
    logic [31:0] exp;
    raddr_valid_i = 1'b1;
    raddr_id_i    = id;
    raddr_addr_i  = addr;
    raddr_len_i   = len;
    rdata_ready_i = 1'b0;
    n = 0;
    while (!raddr_ready_o && n < 50) begin tick(); n++; end
    check({tag, "_raddr_ready"}, raddr_ready_o, 1);
    tick();
    raddr_valid_i = 1'b0;
    check({tag, "_first_beat_latency"}, rdata_valid_o, 1);
    for (int b = 0; b <= int'(len); b++) begin
      exp = ref_mem[(int'(addr) + b) % 256];
      n = 0;
      while (!rdata_valid_o && n < 50) begin tick(); n++; end
      stalls = (b == stall_at) ? 5 : (rand_bp ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        rdata_ready_i = (s == stalls);
        check($sformatf("%s_valid_b%0d", tag, b), rdata_valid_o, 1);
        check($sformatf("%s_data_b%0d", tag, b), rdata_data_o, exp);
        check($sformatf("%s_id_b%0d", tag, b), rdata_id_o, id);
        check($sformatf("%s_last_b%0d", tag, b), rdata_last_o, (b == int'(len)));
        tick();
      end
      rdata_ready_i = 1'b0;
    end
    check({tag, "_burst_done"}, rdata_valid_o, 0);
    check({tag, "_raddr_ready_after"}, raddr_ready_o, 1);
  endtask

  initial begin
    int          beats;
    logic [1:0]  resp;
    logic [31:0] old_val;
    logic [3:0]  rid;
    logic [15:0] raddr;
    logic [3:0]  rlen;

    rst_i = 1'b1;
    raddr_valid_i = 1'b0; raddr_id_i = '0; raddr_addr_i = '0; raddr_len_i = '0;
    waddr_valid_i = 1'b0; waddr_id_i = '0; waddr_addr_i = '0; waddr_len_i = '0;
    wdata_valid_i = 1'b0; wdata_data_i = '0; wdata_last_i = 1'b0;
    rdata_ready_i = 1'b0; wresp_ready_i = 1'b0;

    //            id     addr      len   last base          beats resp
    vecs[0] = '{4'd3, 16'h0010, 4'd3,  3, 32'h0000_00A0,  4, 2'b00};
    vecs[1] = '{4'd1, 16'h0040, 4'd3,  1, 32'h0000_00B0,  2, 2'b10};
    vecs[2] = '{4'd2, 16'h0050, 4'd1, -1, 32'h0000_00C0,  2, 2'b10};
    vecs[3] = '{4'd4, 16'h01FF, 4'd1,  1, 32'h0000_00D0,  2, 2'b00};
    vecs[4] = '{4'd6, 16'h8060, 4'd0,  0, 32'h0000_00E0,  1, 2'b00};
    vecs[5] = '{4'd7, 16'h0070, 4'd15, 15, 32'h0000_00F0, 16, 2'b00};
    vecs[6] = '{4'd8, 16'h0090, 4'd2,  7, 32'h0000_0010,  3, 2'b10};
    vecs[7] = '{4'd9, 16'h00A0, 4'd2,  0, 32'h0000_0020,  1, 2'b10};

    // Reset state
    @(negedge clk_i);
    tick();
    check("rst_raddr_ready", raddr_ready_o, 0);
    check("rst_waddr_ready", waddr_ready_o, 0);
    check("rst_wdata_ready", wdata_ready_o, 0);
    check("rst_rdata_valid", rdata_valid_o, 0);
    check("rst_wresp_valid", wresp_valid_o, 0);
    check("rst_rdata_id", rdata_id_o, 0);
    check("rst_rdata_data", rdata_data_o, 0);
    check("rst_wresp_id", wresp_id_o, 0);
    rst_i = 1'b0;
    tick();
    check("post_rst_raddr_ready", raddr_ready_o, 1);
    check("post_rst_waddr_ready", waddr_ready_o, 1);
    check("post_rst_wdata_ready", wdata_ready_o, 0);

    // Fill the whole store with known values so later read-backs are defined.
    for (int k = 0; k < 16; k++) begin
      model_write(16'(k * 16), 4'd15, 15, 32'h5500_0000 + 32'(k * 16), beats, resp);
      do_write(4'(k), 16'(k * 16), 4'd15, 15, 32'h5500_0000 + 32'(k * 16), beats, resp, 1'b0,
               $sformatf("fill%0d", k));
    end

    // Directed write vectors, each read back over its full requested length
    // with upper address bits flipped (they must be ignored).
    for (int r = 0; r < 8; r++) begin
      model_write(vecs[r].addr, vecs[r].len, vecs[r].last_at, vecs[r].base, beats, resp);
      do_write(vecs[r].id, vecs[r].addr, vecs[r].len, vecs[r].last_at, vecs[r].base,
               vecs[r].exp_beats, vecs[r].exp_resp, 1'b0, $sformatf("vec%0d_w", r));
      do_read(vecs[r].id ^ 4'h6, vecs[r].addr ^ 16'h0100, vecs[r].len,
              (r == 0) ? 1 : -1, 1'b0, $sformatf("vec%0d_r", r));
    end

    // Read-first collision on word 0x20, with read and write address
    // handshakes in the same cycle.
    old_val = ref_mem[32'h20];
    raddr_valid_i = 1'b1; raddr_id_i = 4'hA; raddr_addr_i = 16'h0020; raddr_len_i = 4'd0;
    waddr_valid_i = 1'b1; waddr_id_i = 4'hB; waddr_addr_i = 16'h0020; waddr_len_i = 4'd0;
    rdata_ready_i = 1'b0;
    check("rf_both_addr_ready", {raddr_ready_o, waddr_ready_o}, 2'b11);
    tick();
    raddr_valid_i = 1'b0;
    waddr_valid_i = 1'b0;
    check("rf_rdata_valid", rdata_valid_o, 1);
    check("rf_wdata_ready", wdata_ready_o, 1);
    rdata_ready_i = 1'b1;
    wdata_valid_i = 1'b1; wdata_data_i = 32'h1234_5678; wdata_last_i = 1'b1;
    check("rf_old_value_on_beat", rdata_data_o, old_val);
    tick();
    rdata_ready_i = 1'b0;
    wdata_valid_i = 1'b0; wdata_last_i = 1'b0;
    ref_mem[32'h20] = 32'h1234_5678;
    check("rf_read_done", raddr_ready_o, 1);
    check("rf_wresp_valid", wresp_valid_o, 1);
    check("rf_wresp_id", wresp_id_o, 4'hB);
    check("rf_wresp_resp", wresp_resp_o, 2'b00);
    wresp_ready_i = 1'b1;
    tick();
    wresp_ready_i = 1'b0;
    do_read(4'hC, 16'h0020, 4'd0, -1, 1'b0, "rf_after");

    // Reset while the read FSM is mid-burst and the write FSM is in response.
    raddr_valid_i = 1'b1; raddr_id_i = 4'h3; raddr_addr_i = 16'h0010; raddr_len_i = 4'd3;
    waddr_valid_i = 1'b1; waddr_id_i = 4'h4; waddr_addr_i = 16'h0030; waddr_len_i = 4'd0;
    wdata_valid_i = 1'b1; wdata_data_i = 32'h0000_0077; wdata_last_i = 1'b1;
    rdata_ready_i = 1'b0; wresp_ready_i = 1'b0;
    tick();
    raddr_valid_i = 1'b0;
    waddr_valid_i = 1'b0;
    check("mr_wdata_ready", wdata_ready_o, 1);
    tick();
    wdata_valid_i = 1'b0; wdata_last_i = 1'b0;
    ref_mem[32'h30] = 32'h0000_0077;
    check("mr_in_burst", rdata_valid_o, 1);
    check("mr_in_resp", wresp_valid_o, 1);
    rst_i = 1'b1;
    tick();
    check("mr_rdata_valid", rdata_valid_o, 0);
    check("mr_wresp_valid", wresp_valid_o, 0);
    check("mr_raddr_ready", raddr_ready_o, 0);
    check("mr_waddr_ready", waddr_ready_o, 0);
    check("mr_wdata_ready_rst", wdata_ready_o, 0);
    check("mr_rdata_id", rdata_id_o, 0);
    check("mr_wresp_id", wresp_id_o, 0);
    rst_i = 1'b0;
    tick();
    check("mr_rel_raddr_ready", raddr_ready_o, 1);
    check("mr_rel_waddr_ready", waddr_ready_o, 1);
    check("mr_rel_rdata_valid", rdata_valid_o, 0);
    check("mr_rel_wresp_valid", wresp_valid_o, 0);
    model_write(16'h0031, 4'd1, 1, 32'h0000_0099, beats, resp);
    do_write(4'hE, 16'h0031, 4'd1, 1, 32'h0000_0099, beats, resp, 1'b0, "mr_new_w");
    do_read(4'h2, 16'h0030, 4'd2, -1, 1'b0, "mr_new_r");

    // Randomized transactions with random backpressure against the model.
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  wid;
      logic [15:0] waddr;
      logic [3:0]  wlen;
      int          wlast;
      logic [31:0] wbase;
      wid   = 4'($urandom);
      waddr = 16'($urandom);
      wlen  = 4'($urandom_range(0, 15));
      wlast = ($urandom_range(0, 3) != 0) ? int'(wlen) : int'($urandom_range(0, 15));
      wbase = $urandom;
      model_write(waddr, wlen, wlast, wbase, beats, resp);
      do_write(wid, waddr, wlen, wlast, wbase, beats, resp, 1'b1, $sformatf("rnd%0d_w", it));
      rid   = 4'($urandom);
      raddr = ((it % 2) == 0) ? waddr : 16'($urandom);
      rlen  = 4'($urandom_range(0, 15));
      do_read(rid, raddr, rlen, -1, 1'b1, $sformatf("rnd%0d_r", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
